ibram_arbiter: RTL and testbench

- Shares the single port of the instruction scratch RAM between two requesters: the fetch scratch-RAM sub-unit and a loader/debug port.
- The loader port performs program loading and word/byte reads and writes.
- Sits between the fetch sub-unit interface (new_request/ready/data_valid/flush) and the local_memory_interface to the BRAM.
- Fetch has fixed priority, with a starvation guard for the loader. Read latency is 1 cycle.

---
 rtl/ibram_arbiter_pkg.sv | 21 ++
 rtl/ibram_arbiter_if.sv | 64 ++++++
 rtl/ibram_starve_counter.sv | 33 +++
 rtl/ibram_arbiter.sv | 95 +++++++++
 tb/tb_ibram_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ibram_arbiter_pkg.sv
// Shared types and defaults for the instruction scratch-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: response-owner enum, default address width and starvation limit.
package ibram_arbiter_pkg;

  // Word-address width of the instruction scratch RAM.
  localparam int IBRAM_ARB_ADDR_W = 14;

  // Consecutive loader-waiting cycles before the loader is forced through.
  // Legal range 1..15 (the counter is 4 bits wide).
  localparam int IBRAM_ARB_STARVE_LIMIT = 4;

  // Which requester owns the RAM read data returning this cycle.
  typedef enum logic [1:0] {
    IBRAM_IDLE      = 2'd0,
    IBRAM_FETCH_RD  = 2'd1,
    IBRAM_LOADER_RD = 2'd2
  } ibram_arb_owner_t;

endpackage

// File: rtl/ibram_arbiter_if.sv
// Bundle of fetch, loader and RAM-side signals around the scratch-RAM arbiter.
// Latency: n/a (wires only).
// Backpressure: fetch sees f_ready, loader sees l_gnt; the RAM never stalls.
// Ports: fetch (f_*), loader (l_*), RAM (ram_*); modport slave = arbiter,
// modport master = requesters + RAM. IBRAM_ARB_WRITE_FLUSH_EN adds f_refetch.
interface ibram_arbiter_if
  import ibram_arbiter_pkg::*;
#(
  parameter int ADDR_W = IBRAM_ARB_ADDR_W
);

  // fetch side
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_ready;
  logic              f_data_valid;
  logic [31:0]       f_data;
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
  logic              f_refetch;
`endif

  // loader side
  logic              l_req;
  logic              l_we;
  logic [3:0]        l_be;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;

  // RAM side
  logic              ram_en;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  l_req, l_we, l_be, l_addr, l_wdata,
    input  ram_rdata,
    output f_ready, f_data_valid, f_data,
    output l_gnt, l_rvalid, l_rdata,
    output ram_en, ram_be, ram_addr, ram_wdata
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    , output f_refetch
`endif
  );

  modport master (
    output f_req, f_addr, f_flush,
    output l_req, l_we, l_be, l_addr, l_wdata,
    output ram_rdata,
    input  f_ready, f_data_valid, f_data,
    input  l_gnt, l_rvalid, l_rdata,
    input  ram_en, ram_be, ram_addr, ram_wdata
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    , input f_refetch
`endif
  );

endinterface

// File: rtl/ibram_starve_counter.sv
// Saturating count of cycles the loader has waited while fetch won the RAM.
// Latency: hit reflects the registered count, so it asserts the cycle after the limit is reached.
// Backpressure: none; clear has priority over increment.
// Ports: clk, rst, clr, inc in; hit out (count == LIMIT).
module ibram_starve_counter
  import ibram_arbiter_pkg::*;
#(
  parameter int LIMIT = IBRAM_ARB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/ibram_arbiter.sv
// Shares the single instruction scratch-RAM port between fetch (fixed priority) and the loader.
// Latency: accesses are issued combinationally; read data returns 1 cycle after issue.
// Backpressure: fetch stalls via f_ready only when the starved loader is forced; loader holds l_req until l_gnt.
// Ports: clk, rst (async, active high); bus = ibram_arbiter_if.slave (f_*, l_*, ram_*).
// Optional: IBRAM_ARB_WRITE_FLUSH_EN adds f_refetch, a one-cycle pulse after each granted loader write.
module ibram_arbiter
  import ibram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = IBRAM_ARB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  ibram_arbiter_if.slave    bus
);

  ibram_arb_owner_t state, state_nxt;

  logic starve_hit;
  logic force_l;
  logic fetch_win;
  logic l_gnt;

  // Loader has waited STARVE_LIMIT cycles: it takes this cycle and fetch is held off.
  assign force_l   = bus.l_req & starve_hit;
  assign fetch_win = bus.f_req & ~force_l;
  assign l_gnt     = bus.l_req & ~fetch_win;

  // f_ready must not look at f_req, so it is purely the force condition.
  assign bus.f_ready = ~force_l;
  assign bus.l_gnt   = l_gnt;

  ibram_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (l_gnt | ~bus.l_req),
    .inc (bus.l_req & fetch_win),
    .hit (starve_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IBRAM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM mux and response owner for the access issued this cycle.
  // A flush in the issue cycle lets the access go out but marks the slot unowned.
  always_comb begin
    state_nxt     = IBRAM_IDLE;
    bus.ram_en    = 1'b0;
    bus.ram_be    = 4'd0;
    bus.ram_addr  = bus.l_addr;
    bus.ram_wdata = bus.l_wdata;
    if (fetch_win) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.f_addr;
      if (!bus.f_flush) begin
        state_nxt = IBRAM_FETCH_RD;
      end
    end else if (l_gnt) begin
      bus.ram_en = 1'b1;
      bus.ram_be = bus.l_we ? bus.l_be : 4'd0;
      if (!bus.l_we) begin
        state_nxt = IBRAM_LOADER_RD;
      end
    end
  end

  // A flush in the response cycle also drops the fetch word; loader reads ignore flush.
  assign bus.f_data_valid = (state == IBRAM_FETCH_RD) & ~bus.f_flush;
  assign bus.f_data       = bus.ram_rdata;
  assign bus.l_rvalid     = (state == IBRAM_LOADER_RD);
  assign bus.l_rdata      = bus.ram_rdata;

`ifdef IBRAM_ARB_WRITE_FLUSH_EN
  // Code may have been overwritten under the fetch unit: ask for a refetch.
  logic f_refetch_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_refetch_q <= 1'b0;
    end else begin
      f_refetch_q <= l_gnt & bus.l_we;
    end
  end
  assign bus.f_refetch = f_refetch_q;
`endif

  // Fetch must not request while f_ready is low; such a request is dropped.
  a_fetch_protocol : assert property (@(posedge clk) disable iff (rst) bus.f_req |-> bus.f_ready);

endmodule

// File: tb/tb_ibram_arbiter.sv
// Directed bench for ibram_arbiter with a read-first behavioural RAM.
// Latency: RAM data returns one cycle after ram_en, matching the arbiter pipeline.
// Backpressure: stimulus honours f_ready and holds l_req until l_gnt.
module tb_ibram_arbiter;

  logic clk = 1'b0;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ibram_arbiter_if #(.ADDR_W(14)) bus ();

  ibram_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Read-first RAM; word i starts out as 0x1000_0000 | i.
  logic [31:0] mem [0:16383];
  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 | 32'(i);
    bus.ram_rdata = 32'd0;
    forever begin
      @(posedge clk);
      if (bus.ram_en) begin
        rd = mem[bus.ram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
        bus.ram_rdata = rd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.f_req   = 1'b0;
    bus.f_addr  = 14'd0;
    bus.f_flush = 1'b0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_be    = 4'd0;
    bus.l_addr  = 14'd0;
    bus.l_wdata = 32'd0;
  endtask

  task automatic loader(input logic we, input logic [3:0] be, input logic [13:0] a, input logic [31:0] d);
    bus.l_req   = 1'b1;
    bus.l_we    = we;
    bus.l_be    = be;
    bus.l_addr  = a;
    bus.l_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_f_ready", bus.f_ready, 1);
    chk("rst_f_dv", bus.f_data_valid, 0);
    chk("rst_l_gnt", bus.l_gnt, 0);
    chk("rst_l_rvalid", bus.l_rvalid, 0);
    chk("rst_ram_en", bus.ram_en, 0);
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    chk("rst_refetch", bus.f_refetch, 0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Fetch only, back-to-back.
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h10; #1;
    chk("fo0_ready", bus.f_ready, 1);
    chk("fo0_ram_en", bus.ram_en, 1);
    chk("fo0_ram_be", bus.ram_be, 0);
    chk("fo0_ram_addr", bus.ram_addr, 32'h10);
    chk("fo0_dv", bus.f_data_valid, 0);
    @(negedge clk); bus.f_addr = 14'h11; #1;
    chk("fo1_dv", bus.f_data_valid, 1);
    chk("fo1_data", bus.f_data, 32'h1000_0010);
    @(negedge clk); bus.f_addr = 14'h12; #1;
    chk("fo2_ready", bus.f_ready, 1);
    chk("fo2_data", bus.f_data, 32'h1000_0011);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("fo3_dv", bus.f_data_valid, 1);
    chk("fo3_data", bus.f_data, 32'h1000_0012);
    chk("fo3_ram_en", bus.ram_en, 0);
    @(negedge clk); #1;
    chk("fo4_dv", bus.f_data_valid, 0);

    // Loader only: write then read back.
    @(negedge clk); loader(1'b1, 4'hF, 14'h20, 32'hDEAD_BEEF); #1;
    chk("lw_gnt", bus.l_gnt, 1);
    chk("lw_ram_be", bus.ram_be, 32'hF);
    chk("lw_ram_addr", bus.ram_addr, 32'h20);
    chk("lw_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    @(negedge clk); loader(1'b0, 4'h0, 14'h20, 32'd0); #1;
    chk("lr_gnt", bus.l_gnt, 1);
    chk("lr_ram_be", bus.ram_be, 0);
    chk("lr_no_rvalid_after_wr", bus.l_rvalid, 0);
    @(negedge clk); idle(); #1;
    chk("lr_rvalid", bus.l_rvalid, 1);
    chk("lr_rdata", bus.l_rdata, 32'hDEAD_BEEF);
    chk("lr_gnt_idle", bus.l_gnt, 0);
    @(negedge clk); #1;
    chk("lr_rvalid_off", bus.l_rvalid, 0);

    // Starvation: fetch wins four cycles, the fifth goes to the loader.
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h30; loader(1'b0, 4'h0, 14'h21, 32'd0); #1;
    chk("st0_gnt", bus.l_gnt, 0);
    chk("st0_ready", bus.f_ready, 1);
    chk("st0_ram_addr", bus.ram_addr, 32'h30);
    @(negedge clk); bus.f_addr = 14'h31; #1;
    chk("st1_gnt", bus.l_gnt, 0);
    chk("st1_data", bus.f_data, 32'h1000_0030);
    @(negedge clk); bus.f_addr = 14'h32; #1;
    chk("st2_gnt", bus.l_gnt, 0);
    @(negedge clk); bus.f_addr = 14'h33; #1;
    chk("st3_gnt", bus.l_gnt, 0);
    chk("st3_ready", bus.f_ready, 1);
    @(negedge clk); #1;
    chk("st4_ready", bus.f_ready, 0);
    bus.f_req = 1'b0; #1;
    chk("st4_gnt", bus.l_gnt, 1);
    chk("st4_ram_addr", bus.ram_addr, 32'h21);
    chk("st4_dv", bus.f_data_valid, 1);
    chk("st4_data", bus.f_data, 32'h1000_0033);
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h40; bus.l_addr = 14'h22; #1;
    chk("st5_rvalid", bus.l_rvalid, 1);
    chk("st5_rdata", bus.l_rdata, 32'h1000_0021);
    chk("st5_ready", bus.f_ready, 1);
    chk("st5_gnt", bus.l_gnt, 0);
    chk("st5_ram_addr", bus.ram_addr, 32'h40);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("st6_gnt", bus.l_gnt, 1);
    chk("st6_dv", bus.f_data_valid, 1);
    chk("st6_data", bus.f_data, 32'h1000_0040);
    @(negedge clk); idle(); #1;
    chk("st7_rvalid", bus.l_rvalid, 1);
    chk("st7_rdata", bus.l_rdata, 32'h1000_0022);

    // Flush in the response cycle, with a concurrent loader read.
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h50; #1;
    chk("fl0_ram_en", bus.ram_en, 1);
    @(negedge clk); bus.f_req = 1'b0; bus.f_flush = 1'b1; loader(1'b0, 4'h0, 14'h21, 32'd0); #1;
    chk("fl1_dv", bus.f_data_valid, 0);
    chk("fl1_gnt", bus.l_gnt, 1);
    @(negedge clk); bus.l_req = 1'b0; #1;
    chk("fl2_rvalid", bus.l_rvalid, 1);
    chk("fl2_rdata", bus.l_rdata, 32'h1000_0021);
    chk("fl2_dv", bus.f_data_valid, 0);
    // Flush in the issue cycle: access still goes out, response dropped.
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h51; #1;
    chk("fl3_ram_en", bus.ram_en, 1);
    chk("fl3_ram_addr", bus.ram_addr, 32'h51);
    @(negedge clk); idle(); #1;
    chk("fl4_dv", bus.f_data_valid, 0);

    // Byte write merge.
    @(negedge clk); loader(1'b1, 4'hF, 14'h60, 32'h1122_3344); #1;
    chk("bw0_gnt", bus.l_gnt, 1);
    @(negedge clk); loader(1'b1, 4'b0010, 14'h60, 32'h0000_AB00); #1;
    chk("bw1_ram_be", bus.ram_be, 32'h2);
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    chk("bw1_refetch", bus.f_refetch, 1);
`endif
    @(negedge clk); loader(1'b0, 4'h0, 14'h60, 32'd0); #1;
    chk("bw2_rvalid", bus.l_rvalid, 0);
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    chk("bw2_refetch", bus.f_refetch, 1);
`endif
    @(negedge clk); idle(); #1;
    chk("bw3_rvalid", bus.l_rvalid, 1);
    chk("bw3_rdata", bus.l_rdata, 32'h1122_AB44);
`ifdef IBRAM_ARB_WRITE_FLUSH_EN
    chk("bw3_refetch", bus.f_refetch, 0);
`endif

    // Asynchronous reset while a fetch response is pending.
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 14'h70; #1;
    chk("rs0_ram_en", bus.ram_en, 1);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("rs1_dv_pre", bus.f_data_valid, 1);
    rst = 1'b1; #1;
    chk("rs1_dv", bus.f_data_valid, 0);
    chk("rs1_ready", bus.f_ready, 1);
    chk("rs1_ram_en", bus.ram_en, 0);
    chk("rs1_rvalid", bus.l_rvalid, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rs2_dv", bus.f_data_valid, 0);
    @(negedge clk); #1;
    chk("rs3_dv", bus.f_data_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
